// File: rtl/num_scroll_disp.sv
// -----------------------------------------------------------------------------
// num_scroll_disp
// Student-number display sequencer for a multi-digit 7-segment panel.
// A writable digit string is held internally; on each rising p_1s edge a
// DIGITS-wide window of it is decoded to active-low segments and registered.
// Page mode steps the window by DIGITS, scroll mode steps it by one digit.
//
// Optional feature macro: NUM_BLINK_EN (adds blink_mask input + phase bit).
//
// Ports:
//   p_1s        in   1        step clock, all state changes on rising edge
//   rst         in   1        asynchronous active-high reset
//   display     in   1        1 = page mode, 0 = scroll mode
//   hold        in   1        freeze window position and outputs
//   seq_len     in   LW       active string length (clamped to SEQ_LEN)
//   load        in   1        string store write strobe
//   load_addr   in   4        write index (>= SEQ_LEN ignored)
//   load_data   in   4        digit code to write
//   blink_mask  in   DIGITS   (NUM_BLINK_EN only) positions to blink
//   num_bus     out  7*DIGITS segments, position 0 in bits [6:0], {g..a}
//   frame_idx   out  LW       index of the frame on display
//   wrap        out  1        high while the last frame is on display
// -----------------------------------------------------------------------------
module num_scroll_disp #(
  parameter int DIGITS  = 4,
  parameter int SEQ_LEN = 12,
  parameter int LW      = 5
) (
  input  logic                p_1s,
  input  logic                rst,
  input  logic                display,
  input  logic                hold,
  input  logic [LW-1:0]       seq_len,
  input  logic                load,
  input  logic [3:0]          load_addr,
  input  logic [3:0]          load_data,
`ifdef NUM_BLINK_EN
  input  logic [DIGITS-1:0]   blink_mask,
`endif
  output logic [7*DIGITS-1:0] num_bus,
  output logic [LW-1:0]       frame_idx,
  output logic                wrap
);

  // Active-low {g,f,e,d,c,b,a} decode; A is a dash, B-F are blank.
  function automatic logic [6:0] seg7(input logic [3:0] code);
    case (code)
      4'h0:    seg7 = 7'b1000000;
      4'h1:    seg7 = 7'b1111001;
      4'h2:    seg7 = 7'b0100100;
      4'h3:    seg7 = 7'b0110000;
      4'h4:    seg7 = 7'b0011001;
      4'h5:    seg7 = 7'b0010010;
      4'h6:    seg7 = 7'b0000010;
      4'h7:    seg7 = 7'b1111000;
      4'h8:    seg7 = 7'b0000000;
      4'h9:    seg7 = 7'b0010000;
      4'hA:    seg7 = 7'b0111111;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Power-up contents of the string store (the student number).
  function automatic logic [3:0] init_digit(input logic [4:0] j);
    case (j)
      5'd0:    init_digit = 4'h5;
      5'd1:    init_digit = 4'h1;
      5'd2:    init_digit = 4'h5;
      5'd3:    init_digit = 4'h0;
      5'd4:    init_digit = 4'h3;
      5'd5:    init_digit = 4'h0;
      5'd6:    init_digit = 4'h9;
      5'd7:    init_digit = 4'h1;
      5'd8:    init_digit = 4'h0;
      5'd9:    init_digit = 4'h1;
      5'd10:   init_digit = 4'h9;
      5'd11:   init_digit = 4'h5;
      default: init_digit = 4'hF;
    endcase
  endfunction

  logic [3:0]          store_q [SEQ_LEN];
  logic [LW-1:0]       frame_q, frame_d;   // index of the frame to show next
  logic                mode_q;             // display value seen on last live edge
  logic [7*DIGITS-1:0] bus_q, bus_d;
  logic [LW-1:0]       idx_q, idx_d;
  logic                wrap_q, wrap_d;
`ifdef NUM_BLINK_EN
  logic                phase_q;
`endif

  // Next-frame computation: frame count, current index, window contents.
  always_comb begin
    int         len;
    int         nfr_raw;
    int         nfr;
    int         cur;
    int         offs;
    int         pos;
    logic [3:0] dig;

    if (int'(seq_len) > SEQ_LEN) begin
      len = SEQ_LEN;
    end else begin
      len = int'(seq_len);
    end

    if (display) begin
      nfr_raw = (len + DIGITS - 1) / DIGITS;
    end else if (len >= DIGITS) begin
      nfr_raw = len - DIGITS + 1;
    end else begin
      nfr_raw = 1;
    end
    // An empty string still has one (blank) frame.
    nfr = (nfr_raw < 1) ? 1 : nfr_raw;

    // A mode change restarts the cycle; a shrunken length may strand the index.
    if ((display != mode_q) || (int'(frame_q) >= nfr)) begin
      cur = 0;
    end else begin
      cur = int'(frame_q);
    end

    offs = display ? (cur * DIGITS) : cur;

    bus_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      pos = offs + i;
      dig = 4'hF;
      for (int j = 0; j < SEQ_LEN; j++) begin
        dig = ((pos == j) && (j < len)) ? store_q[j] : dig;
      end
`ifdef NUM_BLINK_EN
      if (phase_q && blink_mask[i]) begin
        bus_d[7*i +: 7] = 7'b1111111;
      end else begin
        bus_d[7*i +: 7] = seg7(dig);
      end
`else
      bus_d[7*i +: 7] = seg7(dig);
`endif
    end

    idx_d   = LW'(cur);
    wrap_d  = (cur == nfr - 1);
    frame_d = (cur == nfr - 1) ? '0 : LW'(cur + 1);
  end

  // Frame sequencing and registered outputs; frozen while hold is high.
  always_ff @(posedge p_1s or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      mode_q  <= 1'b0;
      bus_q   <= '1;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
`ifdef NUM_BLINK_EN
      phase_q <= 1'b0;
`endif
    end else if (!hold) begin
      frame_q <= frame_d;
      mode_q  <= display;
      bus_q   <= bus_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
`ifdef NUM_BLINK_EN
      phase_q <= ~phase_q;
`endif
    end
  end

  // String store writes; out-of-range addresses match no entry.
  always_ff @(posedge p_1s or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < SEQ_LEN; j++) begin
        store_q[j] <= init_digit(5'(j));
      end
    end else begin
      for (int j = 0; j < SEQ_LEN; j++) begin
        if (load && (load_addr == 4'(j))) begin
          store_q[j] <= load_data;
        end
      end
    end
  end

  assign num_bus   = bus_q;
  assign frame_idx = idx_q;
  assign wrap      = wrap_q;

endmodule
